// File: rtl/aes_arb_pkg.sv
// Shared types for the AES request arbiter.
// Block width and FSM state encoding.
package aes_arb_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_CLR,
        BUSY,
        RESP
    } state_t;

endpackage

// File: rtl/aes_req_arbiter_rr.sv
// Combinational round-robin picker.
// Searches upward from ptr with wrap; the pointer register lives in the parent.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            any_grant
);

    function automatic int wrap_idx(input int p, input int k);
        return (p + k) % NREQ;
    endfunction

    // Walk from farthest to nearest so the closest requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(int'(ptr), k)]) begin
                grant                          = '0;
                grant[wrap_idx(int'(ptr), k)]  = 1'b1;
                grant_idx = PW'(wrap_idx(int'(ptr), k));
                any_grant                      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one aes_core between NREQ requesters with round-robin grants,
// a load/done sequencer, a stuck-core watchdog and a tagged response.
module aes_req_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int LOAD_CYCLES = 2,
    parameter int TIMEOUT     = 64,
    parameter int IDW         = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*AES_BLK_W-1:0] req_key,
    input  logic [NREQ*AES_BLK_W-1:0] req_plaintext,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [AES_BLK_W-1:0]      rsp_data,
    output logic [IDW-1:0]            rsp_id,
    output logic                      rsp_err,
    output logic                      core_load,
    output logic [AES_BLK_W-1:0]      core_key,
    output logic [AES_BLK_W-1:0]      core_plaintext,
    input  logic                      core_done,
    input  logic [AES_BLK_W-1:0]      core_cyphertext
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LCW = $clog2(LOAD_CYCLES + 1);
    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_CYCLES - 1);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);
    localparam logic [PW-1:0]  PTR_LAST  = PW'(NREQ - 1);

    state_t          state, state_n;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   id_r;
    logic [LCW-1:0]  load_cnt;
    logic [WDW-1:0]  wdog;
    logic [NREQ-1:0] gnt_oh;
    logic [PW-1:0]   gnt_idx;
    logic            any_gnt;
    logic            wd_exp;
    logic            done_hit;
    logic            timeout_hit;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (gnt_oh),
        .grant_idx (gnt_idx),
        .any_grant (any_gnt)
    );

    assign wd_exp = (wdog == WD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        req_ready   = '0;
        core_load   = 1'b0;
        rsp_valid   = 1'b0;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = gnt_oh;
                if (any_gnt) state_n = LOAD;
            end
            LOAD: begin
                core_load = 1'b1;
                if (load_cnt == LOAD_LAST) state_n = WAIT_CLR;
            end
            // A done still high from the previous job must fall first.
            WAIT_CLR: begin
                if (wd_exp) begin
                    timeout_hit = 1'b1;
                    state_n     = RESP;
                end else if (!core_done) begin
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (core_done) begin
                    done_hit = 1'b1;
                    state_n  = RESP;
                end else if (wd_exp) begin
                    timeout_hit = 1'b1;
                    state_n     = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr         <= '0;
            id_r           <= '0;
            load_cnt       <= '0;
            wdog           <= '0;
            core_key       <= '0;
            core_plaintext <= '0;
            rsp_data       <= '0;
            rsp_id         <= '0;
            rsp_err        <= 1'b0;
        end else begin
            if (state == IDLE && any_gnt) begin
                core_key       <= req_key[int'(gnt_idx)*AES_BLK_W +: AES_BLK_W];
                core_plaintext <= req_plaintext[int'(gnt_idx)*AES_BLK_W +: AES_BLK_W];
                id_r           <= gnt_idx;
                rr_ptr         <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PW'(1);
                load_cnt       <= '0;
            end
            if (state == LOAD) load_cnt <= load_cnt + LCW'(1);
            if (state == LOAD && state_n == WAIT_CLR) begin
                wdog <= '0;
            end else if (state == WAIT_CLR || state == BUSY) begin
                wdog <= wdog + WDW'(1);
            end
            if (done_hit) begin
                rsp_data <= core_cyphertext;
                rsp_id   <= IDW'(id_r);
                rsp_err  <= 1'b0;
            end
            if (timeout_hit) begin
                rsp_data <= '0;
                rsp_id   <= IDW'(id_r);
                rsp_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Self-checking bench for aes_req_arbiter with a behavioural aes_core stub
// and a queue-based round-robin reference model.
`timescale 1ns/1ps
module tb_aes_req_arbiter;

    localparam int NREQ = 2;
    localparam int LC   = 2;
    localparam int TO   = 64;
    localparam int IDW  = 3;
    localparam int COMP = 12;

    localparam logic [127:0] FK   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FP   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FC   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] JUNK = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*128-1:0]   req_key;
    logic [NREQ*128-1:0]   req_plaintext;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [127:0]          rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_err;
    logic                  core_load;
    logic [127:0]          core_key;
    logic [127:0]          core_plaintext;
    logic                  core_done = 1'b0;
    logic [127:0]          core_cyphertext = '0;

    logic [127:0] keys [NREQ];
    logic [127:0] pts  [NREQ];

    int tests = 0;
    int fails = 0;
    int mode  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_key[128*g +: 128]       = keys[g];
        assign req_plaintext[128*g +: 128] = pts[g];
    end

    aes_req_arbiter #(
        .NREQ(NREQ), .LOAD_CYCLES(LC), .TIMEOUT(TO), .IDW(IDW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_key         (req_key),
        .req_plaintext   (req_plaintext),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_id          (rsp_id),
        .rsp_err         (rsp_err),
        .core_load       (core_load),
        .core_key        (core_key),
        .core_plaintext  (core_plaintext),
        .core_done       (core_done),
        .core_cyphertext (core_cyphertext)
    );

    // Stub core: FIPS-197 vector is exact, anything else maps to key^pt.
    function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] p);
        if (k == FK && p == FP) return FC;
        return k ^ p;
    endfunction

    // mode 0: normal, 1: done stuck low, 2: stale done held 3 cycles
    int   st_cnt  = 0;
    int   st_hold = 0;
    logic st_run  = 1'b0;
    always @(posedge clk) begin
        if (core_load) begin
            st_run  <= 1'b1;
            st_cnt  <= COMP;
            st_hold <= (mode == 2) ? 3 : 0;
            if (mode == 2) begin
                core_done       <= 1'b1;
                core_cyphertext <= JUNK;
            end else begin
                core_done <= 1'b0;
            end
        end else if (st_run) begin
            if (st_hold > 0) begin
                st_hold <= st_hold - 1;
                if (st_hold == 1) core_done <= 1'b0;
            end else if (mode == 1) begin
                st_cnt <= st_cnt;
            end else if (st_cnt > 1) begin
                st_cnt <= st_cnt - 1;
            end else begin
                core_done       <= 1'b1;
                core_cyphertext <= cipher(core_key, core_plaintext);
                st_run          <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns with rsp_valid seen or bound expired.
    task automatic wait_rsp(input string nm);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_rsp_seen"}, 128'(rsp_valid), 128'(1));
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int last_loads;

    task automatic run_op(input int idx, input logic [127:0] k, input logic [127:0] p,
                          input logic [127:0] ed, input int eid, input string nm);
        int n;
        @(posedge clk);
        #1;
        keys[idx]      = k;
        pts[idx]       = p;
        req_valid      = '0;
        req_valid[idx] = 1'b1;
        rsp_ready      = 1'b1;
        @(negedge clk);
        n = 0;
        while (req_ready[idx] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_grant"}, 128'(req_ready), 128'(1 << idx));
        @(posedge clk);
        #1;
        req_valid  = '0;
        last_loads = 0;
        n          = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 300) begin
            if (core_load === 1'b1) last_loads++;
            @(negedge clk);
            n++;
        end
        chk({nm, "_data"}, rsp_data, ed);
        chk({nm, "_id"}, 128'(rsp_id), 128'(eid));
        chk({nm, "_err"}, 128'(rsp_err), 128'(0));
        @(posedge clk);
    endtask

    typedef struct {
        int           idx;
        logic [127:0] k;
        logic [127:0] p;
        logic [127:0] d;
        int           id;
    } vec_t;

    typedef struct {
        int           id;
        logic [127:0] d;
    } exp_t;

    vec_t vt [4];
    exp_t q [$];

    initial begin
        int n, bad, g;
        bit m_idle;
        int m_ptr;
        logic [NREQ-1:0] acc;
        logic [NREQ-1:0] exp_rdy;
        exp_t e;

        for (int i = 0; i < NREQ; i++) begin
            keys[i] = '0;
            pts[i]  = '0;
        end
        vt[0] = '{0, FK, FP, FC, 0};
        vt[1] = '{1, 128'h1, 128'h2, 128'h3, 1};
        vt[2] = '{1, {4{32'hdeadbeef}}, {4{32'h0000ffff}}, {4{32'hdead4110}}, 1};
        vt[3] = '{0, {16{8'ha5}}, {16{8'h5a}}, {16{8'hff}}, 0};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_core_load", 128'(core_load), 128'(0));
        chk("rst_rsp_data", rsp_data, 128'(0));
        chk("rst_core_key", core_key, 128'(0));
        do_reset();

        // single-requester vectors incl. FIPS-197
        for (int i = 0; i < 4; i++) begin
            run_op(vt[i].idx, vt[i].k, vt[i].p, vt[i].d, vt[i].id, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_loads", i), 128'(last_loads), 128'(LC));
        end

        // both requesters continuously valid: ids alternate from 0
        do_reset();
        keys[0] = 128'h1111; pts[0] = 128'h2222;
        keys[1] = 128'h4444; pts[1] = 128'h8888;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            wait_rsp($sformatf("rr%0d", j));
            chk($sformatf("rr%0d_id", j), 128'(rsp_id), 128'(j % 2));
            chk($sformatf("rr%0d_data", j), rsp_data, cipher(keys[j % 2], pts[j % 2]));
            @(posedge clk);
        end

        // back-pressure: next job (req0) stalls in RESP for 20 cycles
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        wait_rsp("bp");
        chk("bp_id", 128'(rsp_id), 128'(0));
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || req_ready !== 2'b00 ||
                rsp_data !== cipher(keys[0], pts[0])) bad++;
        end
        chk("bp_hold", 128'(bad), 128'(0));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_grant", 128'(req_ready), 128'(2'b10));
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        wait_rsp("bp2");
        chk("bp2_id", 128'(rsp_id), 128'(1));
        @(posedge clk);

        // watchdog: done never rises
        mode = 1;
        #1;
        keys[0] = 128'hc0ffee;
        req_valid = 2'b01;
        @(negedge clk);
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) break;
            n++;
        end
        chk("to_latency", 128'(n), 128'(LC + TO));
        chk("to_err", 128'(rsp_err), 128'(1));
        chk("to_data", rsp_data, 128'(0));
        chk("to_id", 128'(rsp_id), 128'(0));
        @(posedge clk);
        mode = 0;
        run_op(1, 128'h77, 128'h70, 128'h07, 1, "after_to");

        // stale done from the previous job held across the load
        mode = 2;
        run_op(0, 128'habc0, 128'h000d, 128'habcd, 0, "stale");
        mode = 0;

        // asynchronous reset while BUSY
        @(posedge clk);
        #1;
        keys[1] = 128'h55;
        pts[1]  = 128'h0;
        req_valid = 2'b10;
        @(negedge clk);
        n = 0;
        while (req_ready[1] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (6) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("arst_req_ready", 128'(req_ready), 128'(0));
        chk("arst_core_load", 128'(core_load), 128'(0));
        chk("arst_core_key", core_key, 128'(0));
        chk("arst_rsp_data", rsp_data, 128'(0));
        @(negedge clk);
        reset = 1'b0;
        keys[0] = 128'h99;
        pts[0]  = 128'h0;
        req_valid = 2'b11;
        #1;
        chk("arst_regrant", 128'(req_ready), 128'(2'b01));
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        wait_rsp("arst_op");
        chk("arst_op_id", 128'(rsp_id), 128'(0));
        chk("arst_op_data", rsp_data, 128'h99);
        @(posedge clk);

        // randomized traffic against the reference model
        do_reset();
        m_idle = 1'b1;
        m_ptr  = 0;
        q.delete();
        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            g = -1;
            if (m_idle) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("rnd_ready", 128'(req_ready), 128'(exp_rdy));
            if (rsp_valid === 1'b1 && rsp_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected_rsp", 128'(1), 128'(0));
                end else begin
                    e = q.pop_front();
                    chk("rnd_id", 128'(rsp_id), 128'(e.id));
                    chk("rnd_data", rsp_data, e.d);
                    chk("rnd_err", 128'(rsp_err), 128'(0));
                end
                m_idle = 1'b1;
            end
            acc = '0;
            if (g >= 0) begin
                q.push_back('{g, cipher(keys[g], pts[g])});
                m_ptr  = (g + 1) % NREQ;
                m_idle = 1'b0;
                acc[g] = 1'b1;
            end
            @(posedge clk);
            #1;
            if (c >= 800) begin
                req_valid = '0;
                rsp_ready = 1'b1;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!(req_valid[i] && !acc[i] && $urandom_range(7) != 0)) begin
                        req_valid[i] = 1'($urandom_range(1));
                        keys[i] = {$urandom, $urandom, $urandom, $urandom};
                        pts[i]  = {$urandom, $urandom, $urandom, $urandom};
                    end
                end
                rsp_ready = ($urandom_range(3) != 0);
            end
        end
        chk("rnd_drained", 128'(q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_req_arbiter.md
Name: aes_req_arbiter

Overview:
- Shares one aes_core encryption engine between NREQ independent requesters.
- Each requester offers a key/plaintext pair over a valid/ready handshake.
- Round-robin arbitration grants one request, sequences the core's load/done protocol, and returns the ciphertext on a single tagged response channel.
- Includes a watchdog so a stuck core cannot hang the requesters.

Parameters:
- NREQ, 2, number of requesters (2..8).
- LOAD_CYCLES, 2, cycles core_load is held high per operation (>=1).
- TIMEOUT, 64, max cycles in BUSY waiting for core_done before error (>=16; core nominal is ~12).
- IDW, 3, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_key  in  NREQ*128  per-requester key, slice i = [128*i+127:128*i]
- req_plaintext  in  NREQ*128  per-requester plaintext, same slicing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  128  ciphertext, or all-zero on error
- rsp_id  out  IDW  index of the requester served
- rsp_err  out  1  1 = timeout, data invalid
- core_load  out  1  drives aes_core load
- core_key  out  128  drives aes_core key
- core_plaintext  out  128  drives aes_core plaintext
- core_done  in  1  from aes_core done
- core_cyphertext  in  128  from aes_core cyphertext

Behaviour:
- Reset values, applied asynchronously:
  - state = IDLE; rr_ptr = 0.
  - req_ready, rsp_valid, rsp_err, core_load = 0.
  - rsp_data, rsp_id, core_key, core_plaintext = 0.
  - counters = 0.
- FSM states: IDLE, LOAD, WAIT_CLR, BUSY, RESP.
- IDLE:
  - Grant the first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready[grant]=1 combinationally, in IDLE only.
  - On the handshake edge: latch key and plaintext into core_key/core_plaintext, latch grant into id_r, set rr_ptr = grant+1 mod NREQ, go to LOAD.
  - If no valid request, stay in IDLE with no ready asserted.
- LOAD:
  - core_load=1 for exactly LOAD_CYCLES cycles (counter), then go to WAIT_CLR.
- WAIT_CLR:
  - core_load=0.
  - Wait until core_done=0, so a stale done from the previous operation is ignored, then go to BUSY.
  - Watchdog counts here as well.
- BUSY:
  - On core_done=1: register rsp_data=core_cyphertext, rsp_id=id_r, rsp_err=0, go to RESP.
  - If the watchdog reaches TIMEOUT first: rsp_data=0, rsp_err=1, go to RESP.
  - Watchdog is cleared on entry to WAIT_CLR and counts cycles spent in WAIT_CLR+BUSY.
- RESP:
  - rsp_valid=1.
  - Response fields are stable until rsp_ready=1; on that edge go to IDLE.
  - Back-pressure holds the engine; no new grant is made.
- core_key and core_plaintext are stable from the LOAD entry edge until the next grant.
- Minimum latency: handshake edge -> rsp_valid = LOAD_CYCLES + 1 + core compute cycles.
- Throughput: at most one operation in flight; requests are never reordered within a requester.
- Fairness:
  - With all requesters continuously valid, grants go 0,1,...,NREQ-1,0, ...
  - A requester that has won waits at most NREQ-1 other operations.
- req_valid deasserting before ready: no grant, no side effect.
- Requesters must keep data stable while valid && !ready (protocol rule; not checked).
- core_done glitch-high during LOAD: ignored.
- Reset mid-operation: everything returns to reset values immediately and any in-flight result is discarded. The core is left to self-recover because core_load=0.
- rsp_id is zero-extended from the grant index.

Decomposition:
- Package aes_arb_pkg:
  - state_t enum (IDLE, LOAD, WAIT_CLR, BUSY, RESP), 3 bits.
  - localparam AES_BLK_W = 128.
- Sub-module rr_arbiter:
  - Parameterised NREQ.
  - Inputs: req vector, ptr. Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
1. FIPS-197 vector:
   - Stimulus: req0 with key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, rsp_ready=1.
   - Response: rsp_data = 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id=0, rsp_err=0; core_load high exactly 2 cycles.
2. Simultaneous requests:
   - Stimulus: both requesters valid continuously with distinct vectors, 6 operations.
   - Response: rsp_id sequence 0,1,0,1,0,1, each with the correct ciphertext.
3. Back-pressure:
   - Stimulus: rsp_ready=0 for 20 cycles after rsp_valid.
   - Response: rsp_data and rsp_id held stable, req_ready stays 0 throughout, and one cycle after rsp_ready=1 the next grant occurs.
4. Timeout:
   - Stimulus: stub the core with done stuck 0.
   - Response: after TIMEOUT=64 cycles, rsp_valid=1, rsp_err=1, rsp_data=0; the arbiter then serves the next request normally.
5. Stale done:
   - Stimulus: stub the core holding done=1 for 3 cycles after load.
   - Response: no response until done falls and rises again; the ciphertext is taken from the second rise.
6. Reset mid-BUSY:
   - Stimulus: assert reset asynchronously between clock edges.
   - Response: rsp_valid, req_ready and core_load go to 0 immediately; after release the grant restarts at requester 0.
